// File: rtl/als_pkg.sv
`default_nettype none
// ============================================================================
// Module      : als_pkg
// Description : Shared frame geometry and FSM encoding for the ALS emulator.
// Revision    : 1.0 - initial release
// ============================================================================
package als_pkg;

    localparam int ALS_LEAD_Z  = 4;
    localparam int ALS_DATA_W  = 8;
    localparam int ALS_TRAIL_Z = 4;
    localparam int ALS_FRAME_W = ALS_LEAD_Z + ALS_DATA_W + ALS_TRAIL_Z;

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } als_state_e;

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : edge_sync
// Description : Multi-flop synchronizer with one extra registered copy for
//               level, rise and fall detection of an asynchronous input.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/als_sensor_emu.sv
`default_nettype none
// ============================================================================
// Module      : als_sensor_emu
// Description : SPI responder emulating the ambient-light sensor ADC; shifts
//               a zero-padded sample frame out on sdo on each sck fall.
// Revision    : 1.0 - initial release
// ============================================================================
module als_sensor_emu
    import als_pkg::*;
#(
    parameter int DATA_W      = ALS_DATA_W,
    parameter int LEAD_Z      = ALS_LEAD_Z,
    parameter int TRAIL_Z     = ALS_TRAIL_Z,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ncs,
    input  logic              sck,
    output logic              sdo,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_we,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_short
);

    localparam int FRAME_W  = LEAD_Z + DATA_W + TRAIL_Z;
    localparam int CNT_W    = $clog2(FRAME_W + 1);
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic w_ncs_level;
    logic w_ncs_rise;
    logic w_ncs_fall;
    logic w_sck_fall;
    logic w_unused_sck_level;
    logic w_unused_sck_rise;

    edge_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_ncs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (ncs),
        .level_o (w_ncs_level),
        .rise_o  (w_ncs_rise),
        .fall_o  (w_ncs_fall)
    );

    edge_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sck_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (sck),
        .level_o (w_unused_sck_level),
        .rise_o  (w_unused_sck_rise),
        .fall_o  (w_sck_fall)
    );

    als_state_e          state_q,  state_d;
    logic [FRAME_W-1:0]  shreg_q,  shreg_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                short_q,  short_d;
    logic                sdo_q,    sdo_d;
    logic                w_settled;

    // The synchronizer resets to "idle high"; until the real pin level has
    // propagated through it, a high ncs reading cannot be trusted.
    assign w_settled = (settle_q == SETTLE_W'(SYNC_STAGES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_HIGH;
            shreg_q  <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
            sdo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            short_q  <= short_d;
            sdo_q    <= sdo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        short_d  = short_q;
        shadow_d = sample_we ? sample_in : shadow_q;
        settle_d = w_settled ? settle_q : settle_q + 1'b1;

        case (state_q)
            WAIT_HIGH: begin
                busy_d = 1'b0;
                if (w_settled && w_ncs_level) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (w_ncs_fall) begin
                    shreg_d = {{LEAD_Z{1'b0}}, (sample_we ? sample_in : shadow_q),
                               {TRAIL_Z{1'b0}}};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A coincident sck fall is dropped: the frame is already over.
                if (w_ncs_rise) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    short_d = (cnt_q < CNT_W'(FRAME_W));
                    state_d = IDLE;
                end else if (w_sck_fall) begin
                    shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                    if (cnt_q < CNT_W'(FRAME_W)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = WAIT_HIGH;
                busy_d  = 1'b0;
            end
        endcase

        sdo_d = (state_d == SHIFT) & shreg_d[FRAME_W-1];
    end

    assign sdo         = sdo_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_short = short_q;

endmodule
`default_nettype wire
